// File: rtl/unsigned_mul_8x8_ha_array_reducer_if.sv
// Bus between the half-adder array front-end, this reducer and the product consumer.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1; a
// producer holds valid and its data until that edge, and ready may depend on the other side's state.
interface unsigned_mul_8x8_ha_array_reducer_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  ha_array_0_b;
  logic [6:0]  ha_array_1_b;
  logic [6:0]  ha_array_2_b;
  logic [6:0]  ha_array_3_b;
  logic [8:0]  ha_array_0_t;
  logic [8:0]  ha_array_1_t;
  logic [8:0]  ha_array_2_t;
  logic [8:0]  ha_array_3_t;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic [16:0] sum_full;
  logic        ovf;

  modport master (
    output in_valid, ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b,
           ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t, out_ready,
    input  in_ready, out_valid, product, sum_full, ovf
  );

  modport slave (
    input  in_valid, ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b,
           ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t, out_ready,
    output in_ready, out_valid, product, sum_full, ovf
  );
endinterface

// File: rtl/unsigned_mul_8x8_ha_array_reducer.sv
// Captures one set of four half-adder array pairs and sums them, APC arrays per cycle,
// into a 17-bit result held (saturated to 16 bits on product) until the consumer takes it.
module unsigned_mul_8x8_ha_array_reducer #(
  parameter int APC = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  unsigned_mul_8x8_ha_array_reducer_if.slave   bus,
  output logic [1:0]                           dbg_state
);

  if (!(APC == 1 || APC == 2 || APC == 4)) begin : g_bad_apc
    $error("APC must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [16:0] acc_q, acc_d;
  logic [8:0]  cap_t_q [4];
  logic [8:0]  cap_t_d [4];
  logic [6:0]  cap_b_q [4];
  logic [6:0]  cap_b_d [4];
  logic        out_valid_q, out_valid_d;
  logic [15:0] product_q, product_d;
  logic [16:0] sum_full_q, sum_full_d;
  logic        ovf_q, ovf_d;

  logic [8:0]  in_t [4];
  logic [6:0]  in_b [4];
  logic [16:0] term [4];
  logic [16:0] acc_sum;
  logic        in_ready;
  logic        accept;
  logic        last;

  assign in_t[0] = bus.ha_array_0_t;
  assign in_t[1] = bus.ha_array_1_t;
  assign in_t[2] = bus.ha_array_2_t;
  assign in_t[3] = bus.ha_array_3_t;
  assign in_b[0] = bus.ha_array_0_b;
  assign in_b[1] = bus.ha_array_1_b;
  assign in_b[2] = bus.ha_array_2_b;
  assign in_b[3] = bus.ha_array_3_b;

  // A new set is only taken when the previous product is gone or leaving this edge.
  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign last     = (idx_q == 2'(4 - APC));

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      term[k] = ({8'd0, cap_t_q[k]} + {8'd0, cap_b_q[k], 2'b00}) << (2 * k);
    end
    acc_sum = acc_q;
    for (int a = 0; a < APC; a++) begin
      acc_sum = acc_sum + term[idx_q + 2'(a)];
    end

    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    cap_t_d     = cap_t_q;
    cap_b_d     = cap_b_q;
    out_valid_d = out_valid_q;
    product_d   = product_q;
    sum_full_d  = sum_full_q;
    ovf_d       = ovf_q;

    case (state_q)
      IDLE: ;
      ACCUM: begin
        acc_d = acc_sum;
        idx_d = idx_q + 2'(APC);
        if (last) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          sum_full_d  = acc_sum;
          ovf_d       = acc_sum[16];
          product_d   = acc_sum[16] ? 16'hFFFF : acc_sum[15:0];
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Capture overrides the IDLE fall-back so a held in_valid runs back-to-back.
    if (accept) begin
      cap_t_d = in_t;
      cap_b_d = in_b;
      acc_d   = '0;
      idx_d   = '0;
      state_d = ACCUM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      product_q   <= '0;
      sum_full_q  <= '0;
      ovf_q       <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        cap_t_q[k] <= '0;
        cap_b_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      product_q   <= product_d;
      sum_full_q  <= sum_full_d;
      ovf_q       <= ovf_d;
      cap_t_q     <= cap_t_d;
      cap_b_q     <= cap_b_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;
  assign bus.sum_full  = sum_full_q;
  assign bus.ovf       = ovf_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_unsigned_mul_8x8_ha_array_reducer.sv
// Bench for the half-adder array reducer: three instances (APC = 1, 2, 4) share data and reset
// and each has its own in_valid/out_ready; results are checked against an arithmetic model.
module tb_unsigned_mul_8x8_ha_array_reducer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]  iv;
  logic [2:0]  oready;
  logic [2:0]  ir;
  logic [2:0]  ov;
  logic [2:0]  ovf_o;
  logic [15:0] prod [3];
  logic [16:0] sf [3];
  logic [1:0]  dbg [3];
  logic [8:0]  t_in [4];
  logic [6:0]  b_in [4];

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    unsigned_mul_8x8_ha_array_reducer_if bus ();
    assign bus.in_valid     = iv[g];
    assign bus.out_ready    = oready[g];
    assign bus.ha_array_0_t = t_in[0];
    assign bus.ha_array_1_t = t_in[1];
    assign bus.ha_array_2_t = t_in[2];
    assign bus.ha_array_3_t = t_in[3];
    assign bus.ha_array_0_b = b_in[0];
    assign bus.ha_array_1_b = b_in[1];
    assign bus.ha_array_2_b = b_in[2];
    assign bus.ha_array_3_b = b_in[3];
    assign ir[g]    = bus.in_ready;
    assign ov[g]    = bus.out_valid;
    assign ovf_o[g] = bus.ovf;
    assign prod[g]  = bus.product;
    assign sf[g]    = bus.sum_full;

    unsigned_mul_8x8_ha_array_reducer #(.APC(1 << g)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg[g])
    );
  end

  // Reference: weight each array by its bit positions and add.
  function automatic int model_sum(input logic [8:0] t [4], input logic [6:0] b [4]);
    int s = 0;
    for (int k = 0; k < 4; k++) s += (int'(t[k]) + 4 * int'(b[k])) * (1 << (2 * k));
    return s;
  endfunction

  task automatic rand_set(output logic [8:0] t [4], output logic [6:0] b [4]);
    for (int k = 0; k < 4; k++) begin
      t[k] = 9'($urandom_range(0, 511));
      b[k] = 7'($urandom_range(0, 127));
    end
  endtask

  // Captures one set on instance j, waits for the result, checks it, then consumes it.
  task automatic run_set(input int j, input logic [8:0] t [4], input logic [6:0] b [4],
                         input bit scramble);
    int s, n, cycles, waitc;
    logic [15:0] exp_p;
    logic [8:0]  rt [4];
    logic [6:0]  rb [4];
    s     = model_sum(t, b);
    exp_p = (s > 65535) ? 16'hFFFF : 16'(s);
    n     = 4 >> j;
    waitc = 0;
    while (!ir[j] && waitc < 20) begin @(negedge clk); waitc++; end
    total++;
    if (ir[j] !== 1'b1) begin bad++; $display("FAIL ready_wait j=%0d got=%b exp=1", j, ir[j]); end
    t_in = t; b_in = b; iv[j] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[j] = 1'b0;
    cycles = 1;
    while (!ov[j] && cycles < 20) begin
      if (scramble) begin
        rand_set(rt, rb);
        t_in = rt; b_in = rb;
        iv[j] = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      cycles++;
    end
    iv[j] = 1'b0;
    total++;
    if (cycles !== n + 1) begin bad++; $display("FAIL latency j=%0d got=%0d exp=%0d", j, cycles, n + 1); end
    total++;
    if (prod[j] !== exp_p) begin bad++; $display("FAIL product j=%0d got=%h exp=%h", j, prod[j], exp_p); end
    total++;
    if (sf[j] !== 17'(s)) begin bad++; $display("FAIL sum_full j=%0d got=%0d exp=%0d", j, sf[j], s); end
    total++;
    if (ovf_o[j] !== (s > 65535)) begin bad++; $display("FAIL ovf j=%0d got=%b exp=%b", j, ovf_o[j], s > 65535); end
    oready[j] = 1'b1;
    @(negedge clk);
    oready[j] = 1'b0;
    total++;
    if (ov[j] !== 1'b0) begin bad++; $display("FAIL consume j=%0d got=%b exp=0", j, ov[j]); end
  endtask

  task automatic test_reset();
    rst = 1'b1; iv = '0; oready = '0;
    for (int k = 0; k < 4; k++) begin t_in[k] = '0; b_in[k] = '0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      total++;
      if (ir[j] !== 1'b1) begin bad++; $display("FAIL reset_in_ready j=%0d got=%b exp=1", j, ir[j]); end
      total++;
      if (ov[j] !== 1'b0) begin bad++; $display("FAIL reset_out_valid j=%0d got=%b exp=0", j, ov[j]); end
      total++;
      if (prod[j] !== 16'h0) begin bad++; $display("FAIL reset_product j=%0d got=%h exp=0", j, prod[j]); end
      total++;
      if (sf[j] !== 17'h0) begin bad++; $display("FAIL reset_sum_full j=%0d got=%h exp=0", j, sf[j]); end
      total++;
      if (ovf_o[j] !== 1'b0) begin bad++; $display("FAIL reset_ovf j=%0d got=%b exp=0", j, ovf_o[j]); end
    end
  endtask

  task automatic test_directed();
    logic [8:0] t [4];
    logic [6:0] b [4];
    for (int k = 0; k < 4; k++) begin t[k] = '0; b[k] = '0; end
    t[0] = 9'h001;
    run_set(0, t, b, 1'b0);
    t[0] = 9'h000; t[3] = 9'h1FF; b[3] = 7'h7F;
    run_set(1, t, b, 1'b0);
    for (int k = 0; k < 4; k++) begin t[k] = 9'h1FF; b[k] = 7'h7F; end
    run_set(2, t, b, 1'b0);
  endtask

  task automatic test_random();
    logic [8:0] t [4];
    logic [6:0] b [4];
    for (int j = 0; j < 3; j++) begin
      for (int r = 0; r < 15; r++) begin
        rand_set(t, b);
        run_set(j, t, b, 1'b0);
      end
    end
  endtask

  task automatic test_isolation();
    logic [8:0] t [4];
    logic [6:0] b [4];
    for (int j = 0; j < 3; j++) begin
      for (int r = 0; r < 4; r++) begin
        rand_set(t, b);
        run_set(j, t, b, 1'b1);
      end
    end
  endtask

  // Holds the product under back-pressure, then consumes it while capturing the next set.
  task automatic test_back_to_back(input int j);
    logic [8:0]  t [4];
    logic [6:0]  b [4];
    logic [16:0] exp_q [$];
    logic [16:0] e;
    int s, n, cycles;
    n = 4 >> j;
    rand_set(t, b);
    exp_q.push_back(17'(model_sum(t, b)));
    t_in = t; b_in = b; iv[j] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[j] = 1'b0;
    cycles = 1;
    while (!ov[j] && cycles < 20) begin @(negedge clk); cycles++; end
    e = exp_q.pop_front();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      total++;
      if (ov[j] !== 1'b1 || sf[j] !== e) begin
        bad++; $display("FAIL hold j=%0d c=%0d got=%b/%0d exp=1/%0d", j, c, ov[j], sf[j], e);
      end
      total++;
      if (ir[j] !== 1'b0) begin bad++; $display("FAIL hold_in_ready j=%0d got=%b exp=0", j, ir[j]); end
    end
    rand_set(t, b);
    s = model_sum(t, b);
    exp_q.push_back(17'(s));
    t_in = t; b_in = b; iv[j] = 1'b1; oready[j] = 1'b1;
    #1;
    total++;
    if (ir[j] !== 1'b1) begin bad++; $display("FAIL b2b_in_ready j=%0d got=%b exp=1", j, ir[j]); end
    @(posedge clk);
    @(negedge clk);
    iv[j] = 1'b0; oready[j] = 1'b0;
    total++;
    if (ov[j] !== 1'b0) begin bad++; $display("FAIL b2b_drop j=%0d got=%b exp=0", j, ov[j]); end
    cycles = 1;
    while (!ov[j] && cycles < 20) begin @(negedge clk); cycles++; end
    e = exp_q.pop_front();
    total++;
    if (cycles !== n + 1) begin bad++; $display("FAIL b2b_latency j=%0d got=%0d exp=%0d", j, cycles, n + 1); end
    total++;
    if (sf[j] !== e) begin bad++; $display("FAIL b2b_sum j=%0d got=%0d exp=%0d", j, sf[j], e); end
    total++;
    if (prod[j] !== ((s > 65535) ? 16'hFFFF : 16'(s))) begin
      bad++; $display("FAIL b2b_product j=%0d got=%h sum=%0d", j, prod[j], s);
    end
    oready[j] = 1'b1;
    @(negedge clk);
    oready[j] = 1'b0;
  endtask

  task automatic test_reset_mid_accum();
    logic [8:0] t [4];
    logic [6:0] b [4];
    bit seen;
    rand_set(t, b);
    t_in = t; b_in = b; iv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (ir[0] !== 1'b1) begin bad++; $display("FAIL rst_mid_idle got=%b exp=1", ir[0]); end
    total++;
    if (ov[0] !== 1'b0) begin bad++; $display("FAIL rst_mid_out_valid got=%b exp=0", ov[0]); end
    total++;
    if (prod[0] !== 16'h0) begin bad++; $display("FAIL rst_mid_product got=%h exp=0", prod[0]); end
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin @(negedge clk); seen |= ov[0]; end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL rst_mid_stale got=%b exp=0", seen); end
    for (int k = 0; k < 4; k++) begin t[k] = '0; b[k] = '0; end
    t[1] = 9'h003; b[1] = 7'h01;
    run_set(0, t, b, 1'b0);
    total++;
    if (sf[0] !== 17'd28) begin bad++; $display("FAIL rst_mid_next got=%0d exp=28", sf[0]); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_isolation();
    test_back_to_back(0);
    test_back_to_back(1);
    test_back_to_back(2);
    test_reset_mid_accum();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
